input_conditioner: RTL and testbench



---
 rtl/ring_pkg.sv | 16 +
 rtl/debounce_channel.sv | 67 ++++++
 rtl/input_conditioner.sv | 32 +++
 tb/tb_input_conditioner.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/ring_pkg.sv
// Shared constants for the rotary-ring input path: channel indices and the
// default debounce window.
package ring_pkg;

  localparam int CH_ROT_CLK = 0;
  localparam int CH_ROT_DT  = 1;
  localparam int CH_PUSH    = 2;

  localparam int DEFAULT_STABLE_CYCLES = 5000;

  // A one-cycle window still needs a 1-bit counter to keep the datapath legal.
  function automatic int cnt_width(input int stable_cycles);
    return (stable_cycles > 1) ? $clog2(stable_cycles) : 1;
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One input line: two-flop synchronizer, stability counter and registered
// rise/fall strobes that coincide with the first cycle of the new level.
module debounce_channel
  import ring_pkg::*;
#(
  parameter int   STABLE_CYCLES   = DEFAULT_STABLE_CYCLES,
  parameter logic RESET_LEVEL_BIT = 1'b1
) (
  input  logic clk,
  input  logic res,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall
);

  localparam int            CW       = cnt_width(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);

  logic          sync1_reg;
  logic          s_reg;
  logic          dout_reg, dout_next;
  logic          rise_reg, rise_next;
  logic          fall_reg, fall_next;
  logic [CW-1:0] cnt_reg, cnt_next;

  // Any cycle that agrees with the current level restarts the window, so only
  // an uninterrupted run of STABLE_CYCLES disagreeing samples is accepted.
  always_comb begin
    dout_next = dout_reg;
    cnt_next  = '0;
    rise_next = 1'b0;
    fall_next = 1'b0;
    if (s_reg == dout_reg) begin
      cnt_next = '0;
    end else if (cnt_reg == CNT_LAST) begin
      dout_next = s_reg;
      rise_next = s_reg;
      fall_next = ~s_reg;
    end else begin
      cnt_next = cnt_reg + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      sync1_reg <= RESET_LEVEL_BIT;
      s_reg     <= RESET_LEVEL_BIT;
      dout_reg  <= RESET_LEVEL_BIT;
      cnt_reg   <= '0;
      rise_reg  <= 1'b0;
      fall_reg  <= 1'b0;
    end else begin
      sync1_reg <= din;
      s_reg     <= sync1_reg;
      dout_reg  <= dout_next;
      cnt_reg   <= cnt_next;
      rise_reg  <= rise_next;
      fall_reg  <= fall_next;
    end
  end

  assign dout = dout_reg;
  assign rise = rise_reg;
  assign fall = fall_reg;

endmodule

// File: rtl/input_conditioner.sv
// Synchronises and debounces the rotary CLK/DT and push-button pads; each
// channel is an independent debounce_channel instance.
module input_conditioner
  import ring_pkg::*;
#(
  parameter int                  CHANNELS      = 3,
  parameter int                  STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
  parameter logic [CHANNELS-1:0] RESET_LEVEL   = CHANNELS'(3'b011)
) (
  input  logic                clk,
  input  logic                res,
  input  logic [CHANNELS-1:0] din,
  output logic [CHANNELS-1:0] dout,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall
);

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : gen_ch
    debounce_channel #(
      .STABLE_CYCLES  (STABLE_CYCLES),
      .RESET_LEVEL_BIT(RESET_LEVEL[gi])
    ) u_ch (
      .clk (clk),
      .res (res),
      .din (din[gi]),
      .dout(dout[gi]),
      .rise(rise[gi]),
      .fall(fall[gi])
    );
  end

endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench for input_conditioner with an 8-cycle window; expected strobe
// events are queued by the driver and matched by an independent monitor.
module tb_input_conditioner;

  localparam int SC = 8;

  logic       clk = 1'b0;
  logic       res = 1'b1;
  logic [2:0] din = 3'b011;
  logic [2:0] dout, rise, fall;

  int cyc      = 0;
  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int         cyc;
    logic [2:0] dout;
    logic [2:0] rise;
    logic [2:0] fall;
  } exp_t;
  exp_t sb_q[$];

  input_conditioner #(
    .CHANNELS     (3),
    .STABLE_CYCLES(SC),
    .RESET_LEVEL  (3'b011)
  ) dut (
    .clk (clk),
    .res (res),
    .din (din),
    .dout(dout),
    .rise(rise),
    .fall(fall)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: every strobe must match the oldest queued expectation.
  always @(negedge clk) begin
    if ((rise | fall) !== 3'b000) begin
      if (sb_q.size() == 0) begin
        check("unexpected_strobe", {26'd0, rise, fall}, 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("strobe_cycle", cyc, e.cyc);
        check("strobe_dout", {29'd0, dout}, {29'd0, e.dout});
        check("strobe_rise", {29'd0, rise}, {29'd0, e.rise});
        check("strobe_fall", {29'd0, fall}, {29'd0, e.fall});
        $display("strobe @%0d dout=%b rise=%b fall=%b", cyc, dout, rise, fall);
      end
    end
  end

  initial begin
    int c;
    int r;

    // Reset idle
    res = 1'b1;
    din = 3'b011;
    wait_cyc(3);
    check("reset_dout", {29'd0, dout}, 32'h3);
    check("reset_rise", {29'd0, rise}, 32'h0);
    check("reset_fall", {29'd0, fall}, 32'h0);
    res = 1'b0;
    wait_cyc(200);
    check("idle_dout", {29'd0, dout}, 32'h3);

    // Clean press on channel 2
    c = cyc;
    din[2] = 1'b1;
    sb_q.push_back('{c + 10, 3'b111, 3'b100, 3'b000});
    wait_cyc(20);
    check("press_dout", {29'd0, dout}, 32'h7);

    // Bounce rejection on channel 0
    din[0] = 1'b0; wait_cyc(5);
    din[0] = 1'b1; wait_cyc(2);
    din[0] = 1'b0; wait_cyc(7);
    din[0] = 1'b1; wait_cyc(20);
    check("bounce_dout", {29'd0, dout}, 32'h7);

    // Last-cycle return on channel 1: seven low samples then back high
    din[1] = 1'b0; wait_cyc(7);
    din[1] = 1'b1; wait_cyc(2);
    check("lastcyc_cnt_full", {29'd0, dut.gen_ch[1].u_ch.cnt_reg}, 32'd7);
    wait_cyc(1);
    check("lastcyc_cnt_clear", {29'd0, dut.gen_ch[1].u_ch.cnt_reg}, 32'd0);
    wait_cyc(10);
    check("lastcyc_dout", {29'd0, dout}, 32'h7);

    // One more low sample is enough to fall, then rise again
    c = cyc;
    din[1] = 1'b0;
    sb_q.push_back('{c + 10, 3'b101, 3'b000, 3'b010});
    wait_cyc(8);
    din[1] = 1'b1;
    sb_q.push_back('{c + 18, 3'b111, 3'b010, 3'b000});
    wait_cyc(20);

    // Reset mid-count on channel 2
    res = 1'b1; din = 3'b011; wait_cyc(2);
    res = 1'b0; wait_cyc(2);
    c = cyc;
    din[2] = 1'b1;
    wait_cyc(6);
    check("midcount_cnt", {29'd0, dut.gen_ch[2].u_ch.cnt_reg}, 32'd4);
    res = 1'b1;
    #1;
    check("midreset_dout", {29'd0, dout}, 32'h3);
    check("midreset_strobes", {26'd0, rise, fall}, 32'd0);
    check("midreset_cnt", {29'd0, dut.gen_ch[2].u_ch.cnt_reg}, 32'd0);
    wait_cyc(3);
    r = cyc;
    res = 1'b0;
    sb_q.push_back('{r + 10, 3'b111, 3'b100, 3'b000});
    wait_cyc(20);

    // Channel independence: all change together, channel 1 bounces
    res = 1'b1; din = 3'b011; wait_cyc(2);
    res = 1'b0; wait_cyc(2);
    c = cyc;
    din = 3'b100;
    sb_q.push_back('{c + 10, 3'b110, 3'b100, 3'b001});
    wait_cyc(3);
    din[1] = 1'b1; wait_cyc(2);
    din[1] = 1'b0;
    sb_q.push_back('{c + 15, 3'b100, 3'b000, 3'b010});
    wait_cyc(25);
    check("indep_dout", {29'd0, dout}, 32'h4);

    check("scoreboard_drained", sb_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
